// File: rtl/imaging_pkg.sv
// imaging_pkg: constants and enums shared between the imaging APB slave
// decode and the imaging_apb_reader initiator.
package imaging_pkg;

   // Pixel data word width
   localparam int PIXEL_W = 32;

   // Register map of the imaging APB slave
   localparam logic [31:0] STATUS_ADDR_DEF = 32'h0000_0004;
   localparam logic [31:0] DATA_ADDR_DEF   = 32'h0000_0008;
   localparam int          EMPTY_BIT_DEF   = 0;

   // Frame sequencer states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STAT_SETUP,
      ST_STAT_ACCESS,
      ST_DATA_SETUP,
      ST_DATA_ACCESS,
      ST_PUSH
   } reader_state_t;

   // Single-transfer APB engine phases
   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_ACCESS
   } xfer_phase_t;

endpackage

// File: rtl/imaging_apb_reader_if.sv
// imaging_apb_reader_if: APB3 read-side bus bundle between the reader
// (master) and the imaging register slave.
interface imaging_apb_reader_if;
   import imaging_pkg::*;

   logic               PSEL;
   logic               PENABLE;
   logic               PWRITE;
   logic [31:0]        PADDR;
   logic [31:0]        PWDATA;
   logic [PIXEL_W-1:0] PRDATA;
   logic               PREADY;
   logic               PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/imaging_apb_reader_xfer.sv
// apb_read_xfer: single APB3 read engine. A req sampled on a clock edge
// launches SETUP in the next cycle; ACCESS repeats until PREADY. ack, err
// and rdata are valid in the completing ACCESS cycle so the caller can
// chain the next req straight into a new SETUP with no idle gap.
// Optional ACCESS watchdog: IMAGING_APB_READER_TIMEOUT_EN.
module apb_read_xfer
   import imaging_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                req,
   input  logic [31:0]         addr,
   output logic                ack,
   output logic [PIXEL_W-1:0]  rdata,
   output logic                err,
   imaging_apb_reader_if.master apb
);

   xfer_phase_t phase_reg;
   logic        psel_reg;
   logic        penable_reg;
   logic [31:0] paddr_reg;
   logic        in_access;
   logic        timeout;

   assign apb.PSEL    = psel_reg;
   assign apb.PENABLE = penable_reg;
   assign apb.PADDR   = paddr_reg;
   assign apb.PWRITE  = 1'b0;
   assign apb.PWDATA  = '0;

   assign in_access = (phase_reg == PH_ACCESS);

`ifdef IMAGING_APB_READER_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [CW-1:0] wait_cnt_reg;

   // The TIMEOUT_CYC-th consecutive stalled ACCESS cycle ends the transfer
   assign timeout = in_access && !apb.PREADY &&
                    (wait_cnt_reg == CW'(TIMEOUT_CYC - 1));

   // Count consecutive ACCESS cycles with PREADY low
   always_ff @(posedge clk) begin
      if (!reset) begin
         wait_cnt_reg <= '0;
      end else if (in_access && !apb.PREADY && !timeout) begin
         wait_cnt_reg <= wait_cnt_reg + CW'(1);
      end else begin
         wait_cnt_reg <= '0;
      end
   end
`else
   // Without the watchdog the limit has no effect
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = (TIMEOUT_CYC > 0);
   assign timeout        = 1'b0;
`endif

   assign ack   = in_access && (apb.PREADY || timeout);
   assign err   = in_access && ((apb.PREADY && apb.PSLVERR) || timeout);
   assign rdata = apb.PRDATA;

   // SETUP/ACCESS sequencing with back-to-back chaining on completion
   always_ff @(posedge clk) begin
      if (!reset) begin
         phase_reg   <= PH_IDLE;
         psel_reg    <= 1'b0;
         penable_reg <= 1'b0;
         paddr_reg   <= '0;
      end else begin
         case (phase_reg)
            PH_IDLE: begin
               if (req) begin
                  phase_reg   <= PH_SETUP;
                  psel_reg    <= 1'b1;
                  penable_reg <= 1'b0;
                  paddr_reg   <= addr;
               end
            end
            PH_SETUP: begin
               phase_reg   <= PH_ACCESS;
               penable_reg <= 1'b1;
            end
            PH_ACCESS: begin
               if (ack) begin
                  if (req) begin
                     phase_reg   <= PH_SETUP;
                     psel_reg    <= 1'b1;
                     penable_reg <= 1'b0;
                     paddr_reg   <= addr;
                  end else begin
                     phase_reg   <= PH_IDLE;
                     psel_reg    <= 1'b0;
                     penable_reg <= 1'b0;
                  end
               end
            end
            default: begin
               phase_reg   <= PH_IDLE;
               psel_reg    <= 1'b0;
               penable_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/imaging_apb_reader.sv
// imaging_apb_reader: drains frame_len pixel words from the imaging APB
// slave (poll status until the FIFO is non-empty, then read data) and
// presents each word on a valid/ready stream.
// Optional ACCESS watchdog: define IMAGING_APB_READER_TIMEOUT_EN.
module imaging_apb_reader
   import imaging_pkg::*;
#(
   parameter logic [31:0] STATUS_ADDR = STATUS_ADDR_DEF,
   parameter logic [31:0] DATA_ADDR   = DATA_ADDR_DEF,
   parameter int          EMPTY_BIT   = EMPTY_BIT_DEF,
   parameter int          TIMEOUT_CYC = 255
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [15:0]         frame_len,
   output logic                busy,
   output logic                done,
   output logic                error,
   imaging_apb_reader_if.master apb,
   output logic [PIXEL_W-1:0]  out_data,
   output logic                out_valid,
   input  logic                out_ready
);

   reader_state_t      state_reg;
   logic [15:0]        remaining_reg;
   logic               busy_reg;
   logic               done_reg;
   logic               error_reg;
   logic [PIXEL_W-1:0] out_data_reg;
   logic               out_valid_reg;

   logic               xfer_req;
   logic [31:0]        xfer_addr;
   logic               xfer_ack;
   logic               xfer_err;
   logic [PIXEL_W-1:0] xfer_rdata;

   assign busy      = busy_reg;
   assign done      = done_reg;
   assign error     = error_reg;
   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;

   apb_read_xfer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_xfer (
      .clk   (clk),
      .reset (reset),
      .req   (xfer_req),
      .addr  (xfer_addr),
      .ack   (xfer_ack),
      .rdata (xfer_rdata),
      .err   (xfer_err),
      .apb   (apb)
   );

   // Decide on the same edge as the state change whether a new read launches
   always_comb begin
      xfer_req  = 1'b0;
      xfer_addr = STATUS_ADDR;
      case (state_reg)
         ST_IDLE: begin
            if (start && (frame_len != 16'd0)) begin
               xfer_req = 1'b1;
            end
         end
         ST_STAT_ACCESS: begin
            if (xfer_ack && !xfer_err) begin
               xfer_req = 1'b1;
               if (!xfer_rdata[EMPTY_BIT]) begin
                  xfer_addr = DATA_ADDR;
               end
            end
         end
         ST_PUSH: begin
            if (out_ready && (remaining_reg != 16'd1)) begin
               xfer_req = 1'b1;
            end
         end
         default: begin
            xfer_req = 1'b0;
         end
      endcase
   end

   // Frame sequencer with registered stream and status outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         remaining_reg <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         error_reg     <= 1'b0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  remaining_reg <= frame_len;
                  error_reg     <= 1'b0;
                  if (frame_len == 16'd0) begin
                     done_reg <= 1'b1;
                  end else begin
                     busy_reg  <= 1'b1;
                     state_reg <= ST_STAT_SETUP;
                  end
               end
            end
            ST_STAT_SETUP: begin
               state_reg <= ST_STAT_ACCESS;
            end
            ST_STAT_ACCESS: begin
               if (xfer_ack) begin
                  if (xfer_err) begin
                     error_reg <= 1'b1;
                     done_reg  <= 1'b1;
                     busy_reg  <= 1'b0;
                     state_reg <= ST_IDLE;
                  end else if (xfer_rdata[EMPTY_BIT]) begin
                     state_reg <= ST_STAT_SETUP;
                  end else begin
                     state_reg <= ST_DATA_SETUP;
                  end
               end
            end
            ST_DATA_SETUP: begin
               state_reg <= ST_DATA_ACCESS;
            end
            ST_DATA_ACCESS: begin
               if (xfer_ack) begin
                  if (xfer_err) begin
                     // The faulted word is dropped, never presented
                     error_reg <= 1'b1;
                     done_reg  <= 1'b1;
                     busy_reg  <= 1'b0;
                     state_reg <= ST_IDLE;
                  end else begin
                     out_data_reg  <= xfer_rdata;
                     out_valid_reg <= 1'b1;
                     state_reg     <= ST_PUSH;
                  end
               end
            end
            ST_PUSH: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  remaining_reg <= remaining_reg - 16'd1;
                  if (remaining_reg == 16'd1) begin
                     done_reg  <= 1'b1;
                     busy_reg  <= 1'b0;
                     state_reg <= ST_IDLE;
                  end else begin
                     state_reg <= ST_STAT_SETUP;
                  end
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imaging_apb_reader.sv
// tb_imaging_apb_reader: directed, table-driven bench for imaging_apb_reader
// with a behavioural imaging APB slave (empty-poll count, data wait states,
// PSLVERR injection, stuck PREADY).
module tb_imaging_apb_reader;
   import imaging_pkg::*;

   localparam int TB_TIMEOUT = 255;

   logic        clk       = 1'b0;
   logic        reset     = 1'b0;
   logic        start     = 1'b0;
   logic [15:0] frame_len = 16'd0;
   logic        out_ready = 1'b1;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] out_data;
   logic        out_valid;

   imaging_apb_reader_if apb ();

   imaging_apb_reader #(
      .STATUS_ADDR (STATUS_ADDR_DEF),
      .DATA_ADDR   (DATA_ADDR_DEF),
      .EMPTY_BIT   (EMPTY_BIT_DEF),
      .TIMEOUT_CYC (TB_TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .frame_len (frame_len),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .apb       (apb),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural slave ----------------
   int stat_total  = 0;
   int data_total  = 0;
   int setup_total = 0;
   int wait_cnt    = 0;
   int stat_base   = 0;
   int data_base   = 0;
   int empty_polls = 0;
   int data_waits  = 0;
   int err_word    = -1;
   bit stuck       = 1'b0;

   always @(posedge clk) begin
      if (apb.PSEL && !apb.PENABLE) setup_total <= setup_total + 1;
      if (apb.PSEL && apb.PENABLE) begin
         if (apb.PREADY) begin
            wait_cnt <= 0;
            if (apb.PADDR == STATUS_ADDR_DEF) stat_total <= stat_total + 1;
            else                              data_total <= data_total + 1;
         end else begin
            wait_cnt <= wait_cnt + 1;
         end
      end else begin
         wait_cnt <= 0;
      end
   end

   always_comb begin
      apb.PREADY  = 1'b0;
      apb.PRDATA  = 32'd0;
      apb.PSLVERR = 1'b0;
      if (apb.PSEL && apb.PENABLE) begin
         if (apb.PADDR == STATUS_ADDR_DEF) begin
            apb.PREADY = !stuck;
            apb.PRDATA = {31'd0, ((stat_total - stat_base) < empty_polls)};
         end else begin
            apb.PREADY  = !stuck && (wait_cnt >= data_waits);
            apb.PRDATA  = 32'hA1 + 32'(data_total - data_base);
            apb.PSLVERR = ((data_total - data_base) == err_word);
         end
      end
   end

   // ---------------- checking helpers ----------------
   int          total = 0;
   int          bad   = 0;
   logic [31:0] got [0:7];
   bit          proto_bad;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start, then sample once per cycle until done or budget expiry.
   // lat is measured from the first busy cycle (or from start if busy never rises).
   task automatic run_frame(input int len, input int budget,
                            output int nw, output int lat, output bit seen);
      int   n_busy;
      logic p_sel, p_en, p_rdy, p_val, p_ordy;
      logic [31:0] p_addr, p_data;
      nw = 0; lat = -1; n_busy = -1; seen = 1'b0;
      p_sel = 1'b0; p_en = 1'b0; p_rdy = 1'b0; p_val = 1'b0; p_ordy = 1'b0;
      p_addr = '0; p_data = '0;
      frame_len = 16'(len);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 1; n <= budget && !seen; n++) begin
         if (busy && n_busy < 0) n_busy = n;
         if (apb.PWRITE !== 1'b0 || apb.PWDATA !== 32'd0) proto_bad = 1'b1;
         if (p_sel && !p_en && !(apb.PSEL && apb.PENABLE && apb.PADDR == p_addr)) proto_bad = 1'b1;
         if (p_sel && p_en && !p_rdy && !(apb.PSEL && apb.PENABLE && apb.PADDR == p_addr)) proto_bad = 1'b1;
         if (p_val && !p_ordy && !(out_valid && out_data == p_data)) proto_bad = 1'b1;
         if (out_valid && out_ready) begin
            if (nw < 8) got[nw] = out_data;
            nw++;
         end
         p_sel = apb.PSEL; p_en = apb.PENABLE; p_rdy = apb.PREADY; p_addr = apb.PADDR;
         p_val = out_valid; p_ordy = out_ready; p_data = out_data;
         if (done) begin
            seen = 1'b1;
            lat  = (n_busy < 0) ? n : (n - n_busy);
         end else begin
            tick();
         end
      end
   endtask

   typedef struct {
      int len;
      int empty_polls;
      int data_waits;
      int err_word;
      int exp_words;
      bit exp_err;
      int exp_lat;
      int exp_stat;
      int exp_data;
   } vec_t;

   vec_t vecs [0:4];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int nw, lat, s0, n;
      bit seen;
      logic [31:0] a0;

      // len, empty polls, data waits, error word, words, error, latency, status reads, data reads
      vecs[0] = '{4, 0, 0, -1, 4, 1'b0, 20, 4, 4};
      vecs[1] = '{1, 3, 0, -1, 1, 1'b0, 11, 4, 1};
      vecs[2] = '{2, 0, 3, -1, 2, 1'b0, 16, 2, 2};
      vecs[3] = '{3, 0, 0,  1, 1, 1'b1,  9, 2, 2};
      vecs[4] = '{0, 0, 0, -1, 0, 1'b0,  1, 0, 0};

      // Reset state
      reset = 1'b0;
      tick(); tick(); tick();
      check("rst_psel",      32'(apb.PSEL),    0);
      check("rst_penable",   32'(apb.PENABLE), 0);
      check("rst_pwrite",    32'(apb.PWRITE),  0);
      check("rst_paddr",     apb.PADDR,        0);
      check("rst_pwdata",    apb.PWDATA,       0);
      check("rst_busy",      32'(busy),        0);
      check("rst_done",      32'(done),        0);
      check("rst_error",     32'(error),       0);
      check("rst_out_valid", 32'(out_valid),   0);
      check("rst_out_data",  out_data,         0);
      $display("reset: psel=%0b busy=%0b error=%0b out_valid=%0b", apb.PSEL, busy, error, out_valid);
      reset = 1'b1;
      tick();

      // Table-driven frames
      for (int i = 0; i < 5; i++) begin
         empty_polls = vecs[i].empty_polls;
         data_waits  = vecs[i].data_waits;
         err_word    = vecs[i].err_word;
         stat_base   = stat_total;
         data_base   = data_total;
         s0          = setup_total;
         proto_bad   = 1'b0;
         out_ready   = 1'b1;
         run_frame(vecs[i].len, 600, nw, lat, seen);
         check("done_seen",    32'(seen),  1);
         check("word_count",   32'(nw),    32'(vecs[i].exp_words));
         for (int k = 0; k < nw && k < 8; k++) check("word_value", got[k], 32'hA1 + 32'(k));
         check("error",        32'(error), 32'(vecs[i].exp_err));
         check("busy_at_done", 32'(busy),  0);
         check("latency",      32'(lat),   32'(vecs[i].exp_lat));
         check("status_reads", 32'(stat_total - stat_base), 32'(vecs[i].exp_stat));
         check("data_reads",   32'(data_total - data_base), 32'(vecs[i].exp_data));
         check("apb_setups",   32'(setup_total - s0), 32'(vecs[i].exp_stat + vecs[i].exp_data));
         check("protocol",     32'(proto_bad), 0);
         $display("frame %0d: len=%0d words=%0d latency=%0d error=%0b", i, vecs[i].len, nw, lat, error);
         tick(); tick();
      end

      // Back-pressure: 3 data wait states, out_ready low for 5 cycles
      empty_polls = 0; data_waits = 3; err_word = -1;
      stat_base = stat_total; data_base = data_total;
      out_ready = 1'b0;
      frame_len = 16'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      check("hold_valid_seen", 32'(out_valid), 1);
      a0 = apb.PADDR;
      s0 = setup_total;
      check("hold_paddr_val", a0, DATA_ADDR_DEF);
      for (int k = 0; k < 5; k++) begin
         check("hold_valid", 32'(out_valid), 1);
         check("hold_data",  out_data,       32'hA1);
         check("hold_paddr", apb.PADDR,      a0);
         check("hold_psel",  32'(apb.PSEL),  0);
         tick();
      end
      check("hold_no_xfer", 32'(setup_total - s0), 0);
      out_ready = 1'b1;
      tick();
      check("hold_done",      32'(done),      1);
      check("hold_valid_end", 32'(out_valid), 0);
      $display("backpressure: data=0x%0h paddr=0x%0h done=%0b", out_data, a0, done);
      data_waits = 0;
      tick();

      // start pulsed while busy is ignored
      stat_base = stat_total; data_base = data_total;
      frame_len = 16'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      nw = 0; seen = 1'b0;
      for (int m = 1; m <= 100 && !seen; m++) begin
         if (m == 3) begin
            start = 1'b1;
            frame_len = 16'd5;
         end else begin
            start = 1'b0;
         end
         if (out_valid && out_ready) nw++;
         if (done) seen = 1'b1;
         else      tick();
      end
      start = 1'b0;
      check("busy_start_done",  32'(seen), 1);
      check("busy_start_words", 32'(nw),   2);
      check("busy_start_reads", 32'(data_total - data_base), 2);
      tick(); tick();
      check("busy_start_idle",  32'(busy), 0);
      $display("start-while-busy: words=%0d busy=%0b", nw, busy);

      // Reset asserted during STAT_ACCESS
      stuck = 1'b1;
      frame_len = 16'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!(apb.PSEL && apb.PENABLE) && n < 10) begin
         tick();
         n++;
      end
      check("midrst_in_access", 32'(apb.PSEL && apb.PENABLE), 1);
      reset = 1'b0;
      tick();
      check("midrst_psel",      32'(apb.PSEL),    0);
      check("midrst_penable",   32'(apb.PENABLE), 0);
      check("midrst_paddr",     apb.PADDR,        0);
      check("midrst_busy",      32'(busy),        0);
      check("midrst_done",      32'(done),        0);
      check("midrst_error",     32'(error),       0);
      check("midrst_out_valid", 32'(out_valid),   0);
      check("midrst_out_data",  out_data,         0);
      $display("midframe reset: psel=%0b penable=%0b busy=%0b", apb.PSEL, apb.PENABLE, busy);
      reset = 1'b1;
      stuck = 1'b0;
      tick();
      check("midrst_stays_idle", 32'(apb.PSEL), 0);

`ifdef IMAGING_APB_READER_TIMEOUT_EN
      // Stuck PREADY ends the frame after TB_TIMEOUT stalled ACCESS cycles
      stuck = 1'b1;
      proto_bad = 1'b0;
      run_frame(1, 400, nw, lat, seen);
      check("tmo_done",    32'(seen),     1);
      check("tmo_error",   32'(error),    1);
      check("tmo_latency", 32'(lat),      32'(TB_TIMEOUT + 1));
      check("tmo_psel",    32'(apb.PSEL), 0);
      check("tmo_words",   32'(nw),       0);
      $display("timeout: latency=%0d error=%0b", lat, error);
      stuck = 1'b0;
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
